// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} for HI/LO and stalls the pipeline while busy.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_start,
   input  logic        div_signed,
   input  logic [31:0] div_src1,
   input  logic [31:0] div_src2,
   input  logic        div_annul,
   output logic        div_ready,
   output logic [63:0] div_result,
   output logic        stall_req,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  count;
   logic [31:0] rem, quo, dvs;
   logic        quo_neg, rem_neg;

   logic        accept;
   logic        div_zero;
   logic [31:0] mag_a, mag_b;
   logic [32:0] shifted, diff;
   logic [31:0] rem_nxt, quo_nxt;
   logic [31:0] quo_fix, rem_fix;

   assign accept   = (state == IDLE) && div_start && !div_annul;
   assign div_zero = (div_src2 == 32'd0);

   // Magnitudes are taken as unsigned, so 0x80000000 keeps magnitude 0x80000000.
   always_comb begin
      mag_a = div_src1;
      mag_b = div_src2;
      if (div_signed && div_src1[31]) mag_a = 32'd0 - div_src1;
      if (div_signed && div_src2[31]) mag_b = 32'd0 - div_src2;
   end

   // One restoring step: shift {rem, quo}, trial-subtract the divisor.
   always_comb begin
      shifted = {rem, quo[31]};
      diff    = shifted - {1'b0, dvs};
      if (!diff[32]) begin
         rem_nxt = diff[31:0];
         quo_nxt = {quo[30:0], 1'b1};
      end else begin
         rem_nxt = shifted[31:0];
         quo_nxt = {quo[30:0], 1'b0};
      end
      quo_fix = quo_neg ? (32'd0 - quo_nxt) : quo_nxt;
      rem_fix = rem_neg ? (32'd0 - rem_nxt) : rem_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = div_zero ? DONE : BUSY;
         BUSY:    if (count == 5'd31) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (div_annul) state_nxt = IDLE;
   end

   always_comb begin
      div_ready = (state == DONE);
      stall_req = accept || (state == BUSY);
      fsm_state = state;
   end

   // div_result is loaded on the edge into DONE so it is valid with div_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= 5'd0;
         rem        <= 32'd0;
         quo        <= 32'd0;
         dvs        <= 32'd0;
         quo_neg    <= 1'b0;
         rem_neg    <= 1'b0;
         div_result <= 64'h0;
      end else if (accept) begin
         count   <= 5'd0;
         rem     <= 32'd0;
         quo     <= mag_a;
         dvs     <= mag_b;
         quo_neg <= div_signed && (div_src1[31] ^ div_src2[31]);
         rem_neg <= div_signed && div_src1[31];
         if (div_zero) div_result <= 64'h0;
      end else if (state == BUSY) begin
         rem   <= rem_nxt;
         quo   <= quo_nxt;
         count <= count + 5'd1;
         if ((count == 5'd31) && !div_annul) div_result <= {rem_fix, quo_fix};
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, stall window, signed/unsigned results,
// divide-by-zero, annul, reset and ignored starts.
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_src1;
   logic [31:0] div_src2;
   logic        div_annul;
   logic        div_ready;
   logic [63:0] div_result;
   logic        stall_req;
   logic [1:0]  fsm_state;

   int n_cmp = 0;
   int n_bad = 0;
   int n_rdy;
   int rdy_cyc;
   logic [63:0] exp_q[$];

   div_unit dut (
      .clk        (clk),
      .rst        (rst),
      .div_start  (div_start),
      .div_signed (div_signed),
      .div_src1   (div_src1),
      .div_src2   (div_src2),
      .div_annul  (div_annul),
      .div_ready  (div_ready),
      .div_result (div_result),
      .stall_req  (stall_req),
      .fsm_state  (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_cmp++;
      if (obs !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, want);
      end
   endtask

   // Called once per cycle after inputs settle; pairs each pulse with the queue.
   task automatic sample_ready(input int k);
      if (div_ready) begin
         n_rdy++;
         rdy_cyc = k;
         if (exp_q.size() > 0) check("sb_result", div_result, exp_q.pop_front());
         else                  check("sb_unexpected_ready", 64'd1, 64'd0);
      end
   endtask

   task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] want, input int lat);
      int n_stall;
      n_stall = 0;
      n_rdy   = 0;
      rdy_cyc = -1;
      @(negedge clk);
      div_start  = 1'b1;
      div_signed = sgn;
      div_src1   = a;
      div_src2   = b;
      exp_q.push_back(want);
      #1;
      if (stall_req) n_stall++;
      for (int k = 1; k <= lat + 2; k++) begin
         @(negedge clk);
         if (k == 1) div_start = 1'b0;
         #1;
         if (stall_req) n_stall++;
         sample_ready(k);
      end
      check({tag, "_ready_cycle"}, 64'(rdy_cyc), 64'(lat));
      check({tag, "_ready_count"}, 64'(n_rdy), 64'd1);
      check({tag, "_stall_cycles"}, 64'(n_stall), 64'(lat));
      check({tag, "_state_idle"}, 64'(fsm_state), 64'd0);
   endtask

   initial begin
      rst        = 1'b1;
      div_start  = 1'b0;
      div_signed = 1'b0;
      div_src1   = 32'd0;
      div_src2   = 32'd0;
      div_annul  = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_ready", 64'(div_ready), 64'd0);
      check("reset_stall", 64'(stall_req), 64'd0);
      check("reset_result", div_result, 64'h0);
      check("reset_state", 64'(fsm_state), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("divu_100_7",    1'b0, 32'd100,      32'd7,        {32'd2, 32'd14}, 33);
      run_op("div_m7_2",      1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
      run_op("div_7_m2",      1'b1, 32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33);
      run_op("div_m100_m7",   1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 33);
      run_op("div_min_m1",    1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33);
      run_op("divu_min_2",    1'b0, 32'h80000000, 32'd2,        {32'd0, 32'h40000000}, 33);
      run_op("divu_5_0",      1'b0, 32'd5,        32'd0,        64'h0, 1);
      run_op("divu_max_1",    1'b0, 32'hFFFFFFFF, 32'd1,        {32'd0, 32'hFFFFFFFF}, 33);

      // Annul at T+10, restart 9/3 at T+12.
      n_rdy = 0;
      rdy_cyc = -1;
      @(negedge clk);
      div_start = 1'b1; div_signed = 1'b0; div_src1 = 32'd1000; div_src2 = 32'd3;
      #1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (k == 1)  div_start = 1'b0;
         if (k == 10) div_annul = 1'b1;
         if (k == 11) div_annul = 1'b0;
         if (k == 12) begin
            div_start = 1'b1; div_src1 = 32'd9; div_src2 = 32'd3;
            exp_q.push_back({32'd0, 32'd3});
         end
         if (k == 13) div_start = 1'b0;
         #1;
         if (k == 11) check("annul_state_idle", 64'(fsm_state), 64'd0);
         if (k == 40) check("annul_result_held", div_result, {32'd0, 32'hFFFFFFFF});
         sample_ready(k);
      end
      check("annul_restart_cycle", 64'(rdy_cyc), 64'd45);
      check("annul_ready_count", 64'(n_rdy), 64'd1);

      // Annul and start in the same cycle: start is dropped.
      n_rdy = 0;
      @(negedge clk);
      div_start = 1'b1; div_annul = 1'b1; div_src1 = 32'd20; div_src2 = 32'd4;
      #1;
      check("annul_start_stall", 64'(stall_req), 64'd0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) begin div_start = 1'b0; div_annul = 1'b0; end
         #1;
         if (k == 1) check("annul_start_state", 64'(fsm_state), 64'd0);
         sample_ready(k);
      end
      check("annul_start_no_ready", 64'(n_rdy), 64'd0);

      // div_start toggled with other operands during BUSY and DONE is ignored.
      n_rdy = 0;
      rdy_cyc = -1;
      @(negedge clk);
      div_start = 1'b1; div_signed = 1'b0; div_src1 = 32'd1000; div_src2 = 32'd10;
      exp_q.push_back({32'd0, 32'd100});
      #1;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         if (k >= 2 && k <= 33) begin
            div_start  = (k % 2 == 1);
            div_signed = (k % 3 == 0);
            div_src1   = 32'(k * 77);
            div_src2   = 32'(k);
         end else begin
            div_start = 1'b0;
         end
         #1;
         if (k == 34) check("toggle_state_idle", 64'(fsm_state), 64'd0);
         sample_ready(k);
      end
      check("toggle_ready_cycle", 64'(rdy_cyc), 64'd33);
      check("toggle_ready_count", 64'(n_rdy), 64'd1);

      // Reset at T+5 mid-BUSY.
      n_rdy = 0;
      @(negedge clk);
      div_start = 1'b1; div_signed = 1'b0; div_src1 = 32'd500; div_src2 = 32'd7;
      #1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) div_start = 1'b0;
         if (k == 5) rst = 1'b1;
         if (k == 6) rst = 1'b0;
         #1;
         if (k == 6) begin
            check("rst_mid_ready", 64'(div_ready), 64'd0);
            check("rst_mid_stall", 64'(stall_req), 64'd0);
            check("rst_mid_result", div_result, 64'h0);
            check("rst_mid_state", 64'(fsm_state), 64'd0);
         end
         sample_ready(k);
      end
      check("rst_mid_no_ready", 64'(n_rdy), 64'd0);
      check("sb_leftover", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
